// File: rtl/fetch_pkg.sv
// Shared types, default widths and the constant jump-target table for the fetch sequencer.
package fetch_pkg;

    localparam int FETCH_A       = 10;
    localparam int FETCH_LUT_IDX = 4;
    localparam int FETCH_OFF_W   = 6;
    localparam int FETCH_CNT_W   = 16;

    localparam int JUMP_ENTRIES  = 2 ** FETCH_LUT_IDX;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_RUN  = 2'd1,
        FETCH_DONE = 2'd2
    } fetch_state_t;

    // Listed from entry 15 down to entry 0.
    localparam logic [JUMP_ENTRIES-1:0][FETCH_A-1:0] JUMP_TABLE = {
        10'h3FF, 10'h321, 10'h123, 10'h3FD,
        10'h0FF, 10'h300, 10'h2AA, 10'h155,
        10'h010, 10'h3FE, 10'h080, 10'h200,
        10'h3F0, 10'h100, 10'h040, 10'h000
    };

endpackage

// File: rtl/fetch_ctrl_if.sv
// Decoder-side bundle of the fetch sequencer: decode requests in, PC and status out.
interface fetch_ctrl_if
    import fetch_pkg::*;
#(
    parameter int A       = FETCH_A,
    parameter int LUT_IDX = FETCH_LUT_IDX,
    parameter int OFF_W   = FETCH_OFF_W,
    parameter int CNT_W   = FETCH_CNT_W
) ();

    logic               Start;
    logic               Halt;
    logic               Stall;
    logic               BranchTaken;
    logic               BranchAbs;
    logic [OFF_W-1:0]   BrOffset;
    logic [LUT_IDX-1:0] JumpIdx;

    logic [A-1:0]       InstAddress;
    logic               Running;
    logic               Done;
    logic [CNT_W-1:0]   CycleCount;

    modport master (
        output Start, Halt, Stall, BranchTaken, BranchAbs, BrOffset, JumpIdx,
        input  InstAddress, Running, Done, CycleCount
    );

    modport slave (
        input  Start, Halt, Stall, BranchTaken, BranchAbs, BrOffset, JumpIdx,
        output InstAddress, Running, Done, CycleCount
    );

endinterface

// File: rtl/fetch_ctrl_jump_lut.sv
// Combinational index-to-target lookup over the package jump table.
module jump_lut
    import fetch_pkg::*;
#(
    parameter int A       = FETCH_A,
    parameter int LUT_IDX = FETCH_LUT_IDX
) (
    input  logic [LUT_IDX-1:0] idx,
    output logic [A-1:0]       target
);

    always_comb begin
        target = A'(JUMP_TABLE[idx]);
    end

endmodule

// File: rtl/fetch_ctrl.sv
// PC and fetch sequencer driving the instruction ROM address.
// Optional RUN-cycle counter built only when FETCH_CYCLE_COUNT_EN is defined.
//
//   state | meaning
//   IDLE  | out of reset, PC = 0, nothing executes
//   RUN   | fetching and executing, PC advances per decode inputs
//   DONE  | program ended (halt or end of ROM), PC frozen
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int A       = FETCH_A,
    parameter int LUT_IDX = FETCH_LUT_IDX,
    parameter int OFF_W   = FETCH_OFF_W,
    parameter int CNT_W   = FETCH_CNT_W
) (
    input  logic         Clk,
    input  logic         Reset_n,
    fetch_ctrl_if.slave  bus
);

    localparam logic [1:0] S_IDLE = FETCH_IDLE;
    localparam logic [1:0] S_RUN  = FETCH_RUN;
    localparam logic [1:0] S_DONE = FETCH_DONE;

    logic [1:0]   state_q, state_d;
    logic [A-1:0] pc_q, pc_d;
    logic [A-1:0] jump_target;
    logic [A-1:0] br_offset_ext;
    logic         start_accept;

    jump_lut #(
        .A       (A),
        .LUT_IDX (LUT_IDX)
    ) u_jump_lut (
        .idx    (bus.JumpIdx),
        .target (jump_target)
    );

    assign br_offset_ext = {{(A - OFF_W){bus.BrOffset[OFF_W-1]}}, bus.BrOffset};
    assign start_accept  = bus.Start && (state_q == S_IDLE || state_q == S_DONE);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_accept) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                end
            end
            S_RUN: begin
                if (bus.Halt) begin
                    state_d = S_DONE;
                end else if (bus.Stall) begin
                    pc_d = pc_q;
                end else if (bus.BranchTaken) begin
                    pc_d = bus.BranchAbs ? jump_target : pc_q + br_offset_ext;
                end else if (pc_q == '1) begin
                    // Falling off the last ROM word ends the program in place.
                    state_d = S_DONE;
                end else begin
                    pc_d = pc_q + A'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                pc_d    = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign bus.InstAddress = pc_q;
    assign bus.Running     = (state_q == S_RUN);
    assign bus.Done        = (state_q == S_DONE);

`ifdef FETCH_CYCLE_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The halting edge is still a RUN edge, so it is counted too.
    always_comb begin
        cnt_d = cnt_q;
        if (start_accept) begin
            cnt_d = '0;
        end else if (state_q == S_RUN && cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.CycleCount = cnt_q;
`else
    assign bus.CycleCount = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios then randomized decode traffic.
module tb_fetch_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    fetch_ctrl_if bus ();

    fetch_ctrl u_dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

`ifdef FETCH_CYCLE_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    int lut [16] = '{'h000, 'h040, 'h100, 'h3F0, 'h200, 'h080, 'h3FE, 'h010,
                     'h155, 'h2AA, 'h300, 'h0FF, 'h3FD, 'h123, 'h321, 'h3FF};

    // Reference: program status flags, PC as an integer, RUN-edge count.
    bit m_run;
    bit m_done;
    int m_pc;
    int m_cnt;

    task automatic chk(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},   int'(bus.InstAddress), m_pc);
        chk({tag, ".run"},  int'(bus.Running),     int'(m_run));
        chk({tag, ".done"}, int'(bus.Done),        int'(m_done));
        chk({tag, ".cnt"},  int'(bus.CycleCount),  CNT_EN ? m_cnt : 0);
    endtask

    task automatic model_reset();
        m_run  = 1'b0;
        m_done = 1'b0;
        m_pc   = 0;
        m_cnt  = 0;
    endtask

    task automatic model_step(input bit st, input bit ht, input bit sl, input bit bt,
                              input bit ba, input int off, input int idx);
        if (m_run) begin
            if (m_cnt < 65535) m_cnt++;
            if (ht) begin
                m_run  = 1'b0;
                m_done = 1'b1;
            end else if (sl) begin
                m_pc = m_pc;
            end else if (bt) begin
                if (ba) m_pc = lut[idx];
                else    m_pc = ((m_pc + off) % 1024 + 1024) % 1024;
            end else if (m_pc == 1023) begin
                m_run  = 1'b0;
                m_done = 1'b1;
            end else begin
                m_pc = m_pc + 1;
            end
        end else if (st) begin
            m_run  = 1'b1;
            m_done = 1'b0;
            m_pc   = 0;
            m_cnt  = 0;
        end
    endtask

    task automatic cycle(input string tag, input bit st, input bit ht, input bit sl,
                         input bit bt, input bit ba, input int off, input int idx);
        bus.Start       = st;
        bus.Halt        = ht;
        bus.Stall       = sl;
        bus.BranchTaken = bt;
        bus.BranchAbs   = ba;
        bus.BrOffset    = 6'(off);
        bus.JumpIdx     = 4'(idx);
        @(posedge clk);
        model_step(st, ht, sl, bt, ba, off, idx);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic plain(input string tag);
        cycle(tag, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bus.Start       = 1'b0;
        bus.Halt        = 1'b0;
        bus.Stall       = 1'b0;
        bus.BranchTaken = 1'b0;
        bus.BranchAbs   = 1'b0;
        bus.BrOffset    = '0;
        bus.JumpIdx     = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;
        plain("idle_hold");

        // Start, five plain steps, halt.
        cycle("start", 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) plain("seq");
        cycle("halt", 0, 1, 0, 0, 0, 0, 0);
        chk("halt_pc", int'(bus.InstAddress), 5);
        chk("halt_cnt", int'(bus.CycleCount), CNT_EN ? 6 : 0);

        // Decode inputs are ignored in DONE.
        cycle("done_ign", 0, 0, 0, 1, 1, 0, 2);
        cycle("done_ign", 0, 0, 0, 1, 0, -5, 0);

        // Restart from DONE, relative branches including wrap, end of ROM.
        cycle("restart", 1, 0, 0, 0, 0, 0, 0);
        chk("restart_cnt", int'(bus.CycleCount), 0);
        for (int i = 0; i < 3; i++) plain("to3");
        cycle("rel_m3", 0, 0, 0, 1, 0, -3, 0);
        chk("rel_m3_pc", int'(bus.InstAddress), 0);
        plain("to1");
        cycle("rel_wrap", 0, 0, 0, 1, 0, -2, 0);
        chk("rel_wrap_pc", int'(bus.InstAddress), 'h3FF);
        plain("eorom");
        chk("eorom_done", int'(bus.Done), 1);
        chk("eorom_pc", int'(bus.InstAddress), 'h3FF);
        plain("eorom_hold");

        // Absolute jump, stall dropping a branch, halt beating a branch.
        cycle("restart2", 1, 0, 0, 0, 0, 0, 0);
        cycle("abs", 0, 0, 0, 1, 1, 0, 2);
        chk("abs_pc", int'(bus.InstAddress), 'h100);
        for (int i = 0; i < 3; i++) begin
            cycle("stall", 0, 0, 1, 1, 0, 5, 0);
            chk("stall_pc", int'(bus.InstAddress), 'h100);
        end
        cycle("halt_br", 0, 1, 0, 1, 1, 0, 3);
        chk("halt_br_pc", int'(bus.InstAddress), 'h100);

        // Asynchronous reset in the middle of a program at 0x025.
        cycle("restart3", 1, 0, 0, 0, 0, 0, 0);
        cycle("rel_p31", 0, 0, 0, 1, 0, 31, 0);
        cycle("rel_p6", 0, 0, 0, 1, 0, 6, 0);
        chk("pre_rst_pc", int'(bus.InstAddress), 'h025);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        check_all("rst_hold");
        cycle("post_rst", 1, 0, 0, 0, 0, 0, 0);

        // Randomized decode traffic.
        for (int i = 0; i < 1500; i++) begin
            bit st, ht, sl, bt, ba;
            int r, off, idx;
            st  = ($urandom_range(0, 2) == 0);
            ht  = ($urandom_range(0, 19) == 0);
            sl  = ($urandom_range(0, 4) == 0);
            bt  = ($urandom_range(0, 3) == 0);
            ba  = $urandom_range(0, 1) == 1;
            r   = int'($urandom_range(0, 63));
            off = (r >= 32) ? r - 64 : r;
            idx = int'($urandom_range(0, 15));
            cycle("rand", st, ht, sl, bt, ba, off, idx);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Program-counter and fetch sequencer that drives `InstAddress` of the instruction ROM (A=10, W=9) one stage upstream of it. It starts a program on `Start` and steps the PC once per cycle. It applies relative branches and LUT-based absolute jumps requested by the decoder, holds on stall, and stops on halt or end of ROM. The ROM read is combinational, so ROM, decode and the branch/halt inputs for the current PC all resolve within the same cycle.

## Interface
- `A`, 10, PC/ROM address width.
- `LUT_IDX`, 4, jump-LUT index width (2**LUT_IDX entries).
- `OFF_W`, 6, signed relative-branch offset width.
- `CNT_W`, 16, cycle-counter width.

- `Clk`  in  1  single clock, rising edge.
- `Reset_n`  in  1  reset, asynchronous, active-low.
- `Start`  in  1  begin program; sampled in IDLE and DONE only.
- `Halt`  in  1  current instruction is halt.
- `Stall`  in  1  hold PC this cycle.
- `BranchTaken`  in  1  control transfer for current instruction.
- `BranchAbs`  in  1  1 = absolute jump via LUT, 0 = PC-relative.
- `BrOffset`  in  OFF_W  signed relative offset.
- `JumpIdx`  in  LUT_IDX  jump-LUT index.
- `InstAddress`  out  A  current PC, to the ROM.
- `Running`  out  1  state == RUN.
- `Done`  out  1  state == DONE.
- `CycleCount`  out  CNT_W  RUN-cycle count.

## Operation
- States:
  - IDLE: PC = 0, nothing executes.
  - RUN: fetching and executing.
  - DONE: program ended, PC frozen.
- IDLE: `Start`=1 → RUN; PC stays 0, so address 0 is the first fetch.
- RUN: next-PC priority is Halt > Stall > BranchTaken > increment.
  - `Halt`=1: → DONE, PC holds.
  - `Stall`=1: PC holds, branch inputs ignored.
  - `BranchTaken`&`BranchAbs`: PC = `jump_lut[JumpIdx]`.
  - `BranchTaken`&!`BranchAbs`: PC = PC + sign-extended `BrOffset`, mod 2**A. Wrap is legal and silent.
  - Otherwise PC + 1. At PC = 2**A−1 this is an implicit halt: → DONE, PC holds at 2**A−1.
- DONE: `Start`=1 → PC = 0, RUN. This is a restart without passing through IDLE.
- All decode inputs are ignored outside RUN.
- `Reset_n` low at any time, including mid-program:
  - immediately forces IDLE.
  - `InstAddress`=0, `Running`=0, `Done`=0, `CycleCount`=0.

## Timing
- All state, PC and counter updates occur on the rising edge of `Clk`. Reset is the only asynchronous path.
- Outputs are registered.
- `InstAddress` changes exactly one cycle after the edge that samples the controlling input. Branch penalty is 0 cycles.
- `Start` sampled at edge N (IDLE or DONE) → `Running`=1 after edge N; PC 0 is presented during cycle N+1.
- `Halt` sampled at edge N → `Done`=1 and `Running`=0 after edge N; `InstAddress` is unchanged.
- Simultaneous `Halt`+`BranchTaken`: halt wins and PC does not move.
- Simultaneous `Stall`+`BranchTaken`: the branch is dropped. The decoder must re-present it.
- `Reset_n` deassertion must meet recovery to `Clk`. The first edge after deassertion sees IDLE.

## Configuration
- `FETCH_CYCLE_COUNT_EN` defined:
  - `CycleCount` increments on every edge in RUN, including the halting edge.
  - Clears to 0 on the edge that accepts `Start`.
  - Saturates at 2**CNT_W−1 and holds in IDLE/DONE.
- Not defined: `CycleCount` is tied to 0 and no counter register is built. The port remains.

## Structure
- Package `fetch_pkg` holds:
  - the state enum `fetch_state_t` (IDLE, RUN, DONE).
  - the default widths.
  - the constant jump-target table, 2**LUT_IDX entries of A bits.
- Sub-module `jump_lut` is a combinational index → target lookup over the package table. `fetch_ctrl` instantiates it once.

## Test plan
- Reset mid-RUN at PC=0x025 → `InstAddress`=0, `Running`=0, `Done`=0 and `CycleCount`=0 immediately, before any clock edge.
- `Start` pulse, 5 plain cycles, then `Halt` → addresses 0,1,2,3,4,5 in turn. `Done`=1 with PC=5. `CycleCount`=6 when `FETCH_CYCLE_COUNT_EN` is defined, 0 otherwise.
- Relative branch at PC=3 with `BrOffset`=−3 → PC=0. At PC=1 with `BrOffset`=−2 → PC=0x3FF (wrap).
- Absolute jump `JumpIdx`=2 with LUT[2]=0x100 → next PC=0x100.
- Ends of execution:
  - `Stall` for 3 cycles → PC holds for 3 cycles.
  - `Halt`+`BranchTaken` together → DONE with PC unchanged.
  - Reaching PC=0x3FF with increment → DONE at 0x3FF.
- In DONE, `Start` → PC=0, RUN. `CycleCount` restarts from 0.
